// File: rtl/hamming_decoder.sv
// hamming_decoder
//   Two-stage registered [7,4] Hamming decoder. Stage 1 captures the
//   codeword together with its 3-bit syndrome. Stage 2 corrects any
//   single-bit error and presents the 4 data bits. Valid/ready handshakes
//   are used on both sides. A saturating counter tallies corrected words
//   as they leave the block.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   codeword    received word [6]=d3 [5]=d2 [4]=d1 [3]=d0 [2]=p1 [1]=p2 [0]=p3
//   in_valid    codeword valid
//   in_ready    decoder accepts a codeword this cycle
//   data_out    corrected data {d3,d2,d1,d0}
//   err_pos     syndrome {s2,s1,s0}; 0 = no error
//   corrected   err_pos != 0
//   out_valid   data_out/err_pos/corrected valid
//   out_ready   consumer accepts the output this cycle
//   clr_cnt     synchronous clear of corr_count
//   corr_count  saturating count of corrected words transferred out

module hamming_decoder #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       codeword,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       data_out,
  output logic [2:0]       err_pos,
  output logic             corrected,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] corr_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic       advance;
  logic [2:0] syn_in;
  logic       s1_valid;
  logic [6:0] s1_cw;
  logic [2:0] s1_syn;
  logic [3:0] flip;
  logic [3:0] data_fix;

  // The whole pipeline moves in lockstep. It stalls only when the output
  // holds a word that the consumer is not taking.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  always_comb begin
    syn_in[0] = codeword[2] ^ codeword[3] ^ codeword[4] ^ codeword[6];
    syn_in[1] = codeword[1] ^ codeword[3] ^ codeword[5] ^ codeword[6];
    syn_in[2] = codeword[0] ^ codeword[4] ^ codeword[5] ^ codeword[6];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_cw    <= '0;
      s1_syn   <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_cw  <= codeword;
        s1_syn <= syn_in;
      end
    end
  end

  // Only syndromes that point at a data bit flip anything. Parity-bit
  // syndromes leave the data bits as they are.
  always_comb begin
    flip = '0;
    case (s1_syn)
      3'b011:  flip = 4'b0001;
      3'b101:  flip = 4'b0010;
      3'b110:  flip = 4'b0100;
      3'b111:  flip = 4'b1000;
      default: flip = '0;
    endcase
    data_fix = s1_cw[6:3] ^ flip;
  end

  // A bubble clears out_valid but leaves the last word's fields untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      err_pos   <= '0;
      corrected <= 1'b0;
    end else if (advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        data_out  <= data_fix;
        err_pos   <= s1_syn;
        corrected <= (s1_syn != 3'b000);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_count <= '0;
    end else if (clr_cnt) begin
      corr_count <= '0;
    end else if (out_valid && out_ready && corrected && (corr_count != CNT_MAX)) begin
      corr_count <= corr_count + CNT_W'(1);
    end
  end

endmodule
